// File: rtl/ud_ctrl_pkg.sv
// Shared state encoding and 7-segment direction glyphs for the up/down sweep controller.
package ud_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] glyph(input state_t s);
    case (s)
      ST_UP:   glyph = SEG_U;
      ST_DOWN: glyph = SEG_D;
      default: glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/ud_step_tick.sv
// Step divider: tick fires on the STEP_DIV-th enabled cycle, phase restarts whenever clr is high.
module ud_step_tick #(
  parameter int STEP_DIV = 1
) (
  input  logic cp,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] div;

  assign tick = en && (div == LAST);

  always_ff @(posedge cp) begin
    if (reset || clr) begin
      div <= 8'd0;
    end else if (en) begin
      div <= tick ? 8'd0 : div + 8'd1;
    end
  end

endmodule

// File: rtl/ud_sweep_ctrl.sv
// Up/down sweep controller: single up-sweep or ping-pong between latched bounds,
// with a divided step rate and a registered 7-segment direction glyph.
module ud_sweep_ctrl #(
  parameter int WIDTH    = 4,
  parameter int STEP_DIV = 1
) (
  input  logic             cp,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] cnt,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [6:0]       display
);
  import ud_ctrl_pkg::*;

  state_t           state;
  state_t           nxt;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             mode_q;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic             running;
  logic             tick;
  logic             accept;
  logic             reject;

  assign running = (state == ST_UP) || (state == ST_DOWN);
  assign cnt_inc = cnt + 1'b1;
  assign cnt_dec = cnt - 1'b1;

  // Divider is held cleared outside UP/DOWN; turnarounds land on a tick, which wraps it to 0.
  ud_step_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick (
    .cp    (cp),
    .reset (reset),
    .clr   (~running),
    .en    (running),
    .tick  (tick)
  );

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    reject = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          if (lo < hi) begin
            accept = 1'b1;
            nxt    = ST_UP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (stop) begin
          nxt = ST_IDLE;
        end else if (tick && (cnt_inc == hi_q)) begin
          nxt = mode_q ? ST_DOWN : ST_DONE;
        end
      end
      ST_DOWN: begin
        if (stop) begin
          nxt = ST_IDLE;
        end else if (tick && (cnt_dec == lo_q)) begin
          nxt = ST_UP;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state register.
  always_ff @(posedge cp) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 1'b0;
      dir     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      display <= SEG_BLANK;
    end else begin
      state   <= nxt;
      dir     <= (nxt == ST_UP);
      busy    <= (nxt == ST_UP) || (nxt == ST_DOWN);
      done    <= (nxt == ST_DONE);
      err     <= reject;
      display <= glyph(nxt);
      if (accept) begin
        lo_q   <= lo;
        hi_q   <= hi;
        mode_q <= mode;
        cnt    <= lo;
      end else if (tick && !stop) begin
        if (state == ST_UP) begin
          cnt <= cnt_inc;
        end else if (state == ST_DOWN) begin
          cnt <= cnt_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_ud_sweep_ctrl.sv
// Bench for ud_sweep_ctrl: two instances (STEP_DIV 1 and 3) share stimulus and are
// checked every cycle against a cycle-level behavioural model, plus directed spot checks.
module tb_ud_sweep_ctrl;

  localparam int W = 4;
  localparam int M = 1 << W;
  localparam logic [6:0] G_U = 7'b0111110;
  localparam logic [6:0] G_D = 7'b1011110;

  logic         cp = 1'b0;
  logic         reset, start, stop, mode;
  logic [W-1:0] lo, hi;

  logic [W-1:0] cnt1, cnt3;
  logic         dir1, dir3, busy1, busy3, done1, done3, err1, err3;
  logic [6:0]   disp1, disp3;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0 idle, 1 rising, 2 falling, 3 finished
  int m_ph[2], m_cnt[2], m_lo[2], m_hi[2], m_mode[2], m_wt[2], m_err[2];
  int m_div[2] = '{1, 3};

  always #5 cp = ~cp;

  ud_sweep_ctrl #(.WIDTH(W), .STEP_DIV(1)) dut1 (
    .cp(cp), .reset(reset), .start(start), .stop(stop), .mode(mode), .lo(lo), .hi(hi),
    .cnt(cnt1), .dir(dir1), .busy(busy1), .done(done1), .err(err1), .display(disp1)
  );

  ud_sweep_ctrl #(.WIDTH(W), .STEP_DIV(3)) dut3 (
    .cp(cp), .reset(reset), .start(start), .stop(stop), .mode(mode), .lo(lo), .hi(hi),
    .cnt(cnt3), .dir(dir3), .busy(busy3), .done(done3), .err(err3), .display(disp3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input int k);
    m_err[k] = 0;
    if (reset) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_mode[k] = 0; m_wt[k] = 0;
    end else begin
      case (m_ph[k])
        0: begin
          if (start && !stop) begin
            if (int'(lo) < int'(hi)) begin
              m_lo[k] = int'(lo); m_hi[k] = int'(hi); m_mode[k] = int'(mode);
              m_cnt[k] = int'(lo); m_ph[k] = 1; m_wt[k] = 0;
            end else begin
              m_err[k] = 1;
            end
          end
        end
        1, 2: begin
          if (stop) begin
            m_ph[k] = 0;
          end else begin
            m_wt[k]++;
            if (m_wt[k] == m_div[k]) begin
              m_wt[k] = 0;
              if (m_ph[k] == 1) begin
                m_cnt[k] = (m_cnt[k] + 1) % M;
                if (m_cnt[k] == m_hi[k]) m_ph[k] = (m_mode[k] != 0) ? 2 : 3;
              end else begin
                m_cnt[k] = (m_cnt[k] + M - 1) % M;
                if (m_cnt[k] == m_lo[k]) m_ph[k] = 1;
              end
            end
          end
        end
        default: m_ph[k] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    logic [6:0] g;
    for (int k = 0; k < 2; k++) begin
      g = (m_ph[k] == 1) ? G_U : (m_ph[k] == 2) ? G_D : 7'd0;
      chk($sformatf("cnt%0d", m_div[k]),  8'(k ? cnt3 : cnt1),   8'(m_cnt[k]));
      chk($sformatf("dir%0d", m_div[k]),  8'(k ? dir3 : dir1),   8'(m_ph[k] == 1));
      chk($sformatf("busy%0d", m_div[k]), 8'(k ? busy3 : busy1), 8'(m_ph[k] == 1 || m_ph[k] == 2));
      chk($sformatf("done%0d", m_div[k]), 8'(k ? done3 : done1), 8'(m_ph[k] == 3));
      chk($sformatf("err%0d", m_div[k]),  8'(k ? err3 : err1),   8'(m_err[k]));
      chk($sformatf("disp%0d", m_div[k]), 8'(k ? disp3 : disp1), 8'(g));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge cp);
      model_update(0);
      model_update(1);
      #1;
      compare_all();
    end
  endtask

  initial begin
    int found;
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_cnt[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_mode[k] = 0; m_wt[k] = 0; m_err[k] = 0;
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; lo = '0; hi = '0;
    cyc(2);
    chk("rst_cnt", 8'(cnt1), 8'd0);
    chk("rst_disp", 8'(disp3), 8'd0);
    reset = 1'b0;
    cyc(1);

    // single up-sweep 2..5
    lo = 4'd2; hi = 4'd5; mode = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("ss_load", 8'(cnt1), 8'd2);
    chk("ss_dir", 8'(dir1), 8'd1);
    cyc(1); chk("ss_c3", 8'(cnt1), 8'd3);
    cyc(1); chk("ss_c4", 8'(cnt1), 8'd4);
    cyc(1); chk("ss_c5", 8'(cnt1), 8'd5);
    chk("ss_done", 8'(done1), 8'd1);
    cyc(1);
    chk("ss_done_end", 8'(done1), 8'd0);
    chk("ss_idle_cnt", 8'(cnt1), 8'd5);
    cyc(16);
    chk("ss3_end", 8'(cnt3), 8'd5);

    // ping-pong 1..3; bound/mode inputs change after start and must not matter
    lo = 4'd1; hi = 4'd3; mode = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0; mode = 1'b0; lo = 4'd0; hi = 4'd9;
    cyc(2);
    chk("pp_top", 8'(cnt1), 8'd3);
    chk("pp_top_glyph", 8'(disp1), 8'(G_D));
    cyc(2);
    chk("pp_bot", 8'(cnt1), 8'd1);
    chk("pp_bot_glyph", 8'(disp1), 8'(G_U));
    start = 1'b1;
    cyc(2);
    start = 1'b0;
    chk("pp_latched", 8'(disp1), 8'(G_D));
    cyc(20);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("pp_stop", 8'(busy1), 8'd0);

    // rejected start
    lo = 4'd7; hi = 4'd7; start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("rej_err", 8'(err1), 8'd1);
    chk("rej_busy", 8'(busy3), 8'd0);
    cyc(1);
    chk("rej_pulse", 8'(err1), 8'd0);

    // start with stop in idle
    lo = 4'd1; hi = 4'd4; start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_both_err", 8'(err1), 8'd0);
    chk("ss_both_busy", 8'(busy1), 8'd0);

    // abort on a tick at cnt=9 (STEP_DIV=3 instance)
    lo = 4'd0; hi = 4'd15; mode = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if ((m_ph[1] == 1 || m_ph[1] == 2) && m_cnt[1] == 9 && m_wt[1] == m_div[1] - 1) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    chk("abort_reach", 8'(found), 8'd1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("abort_cnt", 8'(cnt3), 8'd9);
    chk("abort_busy", 8'(busy3), 8'd0);
    chk("abort_disp", 8'(disp3), 8'd0);
    cyc(3);
    chk("abort_nodone", 8'(done3), 8'd0);

    // reset during DOWN at cnt=6
    lo = 4'd0; hi = 4'd15; mode = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (m_ph[1] == 2 && m_cnt[1] == 6) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    chk("mrst_reach", 8'(found), 8'd1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("mrst_cnt", 8'(cnt3), 8'd0);
    chk("mrst_busy", 8'(busy3), 8'd0);
    chk("mrst_disp", 8'(disp3), 8'd0);
    lo = 4'd0; hi = 4'd2; mode = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(12);
    chk("mrst_resweep", 8'(cnt3), 8'd2);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom % 64) == 0;
      stop  = ($urandom % 16) == 0;
      start = ($urandom % 4) == 0;
      mode  = 1'($urandom);
      lo    = W'($urandom);
      hi    = W'($urandom);
      cyc(1);
    end
    reset = 1'b0; stop = 1'b0; start = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ud_sweep_ctrl.md
UD_SWEEP_CTRL -- requirements
Module: ud_sweep_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the count width in bits.
REQ-002 Parameter STEP_DIV, default 1, range 1..255, SHALL set the number of cp cycles per count step.
REQ-003 cp  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL request a sweep (level-sampled, acted on in IDLE only).
REQ-006 stop  input  1  SHALL abort an active sweep.
REQ-007 mode  input  1  SHALL select the sweep type: 0 = single up-sweep, 1 = ping-pong between bounds.
REQ-008 lo, hi  input  WIDTH each  SHALL be the sweep bounds, latched at accepted start.
REQ-009 cnt  output  WIDTH  SHALL be the registered count value.
REQ-010 dir  output  1  SHALL be 1 in UP, 0 otherwise.
REQ-011 busy  output  1  SHALL be 1 in UP or DOWN.
REQ-012 done  output  1  SHALL be a one-cycle pulse at single-sweep completion.
REQ-013 err  output  1  SHALL be a one-cycle pulse when start is rejected.
REQ-014 display  output  7  SHALL be the registered 7-segment direction glyph.

Function
REQ-015 States SHALL be IDLE, UP, DOWN and DONE.
REQ-016 In IDLE with start=1, stop=0 and lo<hi, the block SHALL latch lo/hi, load cnt<=lo, and enter UP on the next edge.
REQ-017 In IDLE with start=1, stop=0 and lo>=hi, the block SHALL stay in IDLE, hold cnt, and pulse err for one cycle.
REQ-018 The step tick SHALL assert once every STEP_DIV cycles in UP/DOWN and SHALL restart its phase at each UP/DOWN entry, so the first step occurs STEP_DIV cycles after entry.
REQ-019 In UP on a tick: cnt<=cnt+1; if cnt+1==hi_q, the next state SHALL be DOWN (mode_q=1) or DONE (mode_q=0).
REQ-020 In DOWN on a tick: cnt<=cnt-1; if cnt-1==lo_q, the next state SHALL be UP.
REQ-021 mode SHALL be latched with the bounds at start; later changes SHALL have no effect on the running sweep.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE holding cnt=hi_q.
REQ-023 stop=1 in UP, DOWN or DONE SHALL force IDLE on the next edge with cnt held and no done pulse; stop SHALL take priority over a simultaneous tick.
REQ-024 start=1 and stop=1 together in IDLE SHALL have no effect; start outside IDLE SHALL be ignored.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH, although the bound checks prevent wrap-around.
REQ-026 display SHALL be 7'b0111110 ("U") in UP, 7'b1011110 ("d") in DOWN, and 7'b0000000 otherwise; it SHALL update in the same cycle as the state register.

Reset
REQ-027 On reset=1 at a cp edge, the block SHALL set state=IDLE, cnt=0, lo_q=0, hi_q=0, mode_q=0, the tick divider to 0, and dir, busy, done, err and display to 0.
REQ-028 Reset SHALL override start, stop and tick in the same cycle, including mid-sweep.

Structure
REQ-029 The state encodings and the U/d/blank segment constants SHALL reside in the shared package ud_ctrl_pkg.
REQ-030 The step divider SHALL be a sub-module ud_step_tick (inputs cp, reset, clr, en; output tick).
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-032 Single sweep: STEP_DIV=1, lo=2, hi=5, mode=0, pulse start -> cnt 2,3,4,5, then done for one cycle, then IDLE with cnt=5.
REQ-033 Ping-pong: lo=1, hi=3, mode=1 -> cnt 1,2,3,2,1,2,3…; display toggles U/d in the cycle cnt reaches 3 or 1.
REQ-034 Reject: lo=7, hi=7, pulse start -> err for one cycle, state stays IDLE, cnt unchanged.
REQ-035 Abort: STEP_DIV=3, ping-pong 0..15, assert stop coincident with a tick while cnt=9 -> cnt stays 9, busy=0, display=0, done never asserts.
REQ-036 Mid-sweep reset: during DOWN with cnt=6, assert reset for one cycle -> all outputs 0 on the next edge; a subsequent start with lo=0, hi=2 sweeps normally.
REQ-037 Simultaneous start and stop in IDLE -> no state change and no err pulse.
